// File: rtl/instr_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/WB sequencer owning PC, IR and CPSR flags.
// Optional perf counters are built when SEQ_PERF_CNT_EN is defined.
module instr_sequencer #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4,
  parameter int unsigned BR_BIAS  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        dmem_busy,
  input  logic [3:0]  alu_nzcv,
  input  logic        flags_we,
  input  logic        bf,
  input  logic [31:0] branchimm,
  output logic [1:0]  state,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [3:0]  cpsr_nzcv,
  output logic        cond_pass,
  output logic        retire,
  output logic        halted,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_retired
);

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    DECODE = 2'b01,
    EXEC   = 2'b10,
    WB     = 2'b11
  } seq_state_t;

  localparam logic [31:0] STEP = 32'(PC_STEP);
  localparam logic [31:0] BIAS = 32'(BR_BIAS);

  seq_state_t  cur_state, nxt_state;
  logic        cond_ok;
  logic [31:0] pc_seq, pc_br, br_off;
  logic        unused_imm_hi;

  assign state         = cur_state;
  assign imem_addr     = pc;
  assign br_off        = {{6{branchimm[23]}}, branchimm[23:0], 2'b00};
  assign pc_seq        = pc + STEP;
  assign pc_br         = pc + BIAS + br_off;
  assign unused_imm_hi = ^branchimm[31:24];

  // ARM condition field evaluated against the architectural flags
  always_comb begin
    cond_ok = 1'b0;
    case (ir[31:28])
      4'h0: cond_ok = cpsr_nzcv[2];
      4'h1: cond_ok = !cpsr_nzcv[2];
      4'h2: cond_ok = cpsr_nzcv[1];
      4'h3: cond_ok = !cpsr_nzcv[1];
      4'h4: cond_ok = cpsr_nzcv[3];
      4'h5: cond_ok = !cpsr_nzcv[3];
      4'h6: cond_ok = cpsr_nzcv[0];
      4'h7: cond_ok = !cpsr_nzcv[0];
      4'h8: cond_ok = cpsr_nzcv[1] && !cpsr_nzcv[2];
      4'h9: cond_ok = !cpsr_nzcv[1] || cpsr_nzcv[2];
      4'hA: cond_ok = (cpsr_nzcv[3] == cpsr_nzcv[0]);
      4'hB: cond_ok = (cpsr_nzcv[3] != cpsr_nzcv[0]);
      4'hC: cond_ok = !cpsr_nzcv[2] && (cpsr_nzcv[3] == cpsr_nzcv[0]);
      4'hD: cond_ok = cpsr_nzcv[2] || (cpsr_nzcv[3] != cpsr_nzcv[0]);
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      FETCH:  if (imem_req && imem_ack) nxt_state = DECODE;
      DECODE: nxt_state = cond_ok ? EXEC : FETCH;
      EXEC:   if (!dmem_busy) nxt_state = WB;
      WB:     nxt_state = FETCH;
      default: nxt_state = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= FETCH;
    else        cur_state <= nxt_state;
  end

  // Leaving an instruction pre-arms the next fetch unless a halt is pending,
  // so an ack in the first FETCH cycle completes the fetch in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= PC_RESET;
      ir        <= 32'h0;
      cpsr_nzcv <= 4'h0;
      imem_req  <= 1'b0;
      cond_pass <= 1'b0;
      retire    <= 1'b0;
      halted    <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (cur_state)
        FETCH: begin
          if (!imem_req) begin
            if (halt_req) begin
              halted <= 1'b1;
            end else begin
              halted   <= 1'b0;
              imem_req <= 1'b1;
            end
          end else if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
          end
        end
        DECODE: begin
          cond_pass <= cond_ok;
          if (!cond_ok) begin
            pc       <= pc_seq;
            retire   <= 1'b1;
            imem_req <= !halt_req;
          end
        end
        WB: begin
          if (flags_we) cpsr_nzcv <= alu_nzcv;
          pc       <= bf ? pc_br : pc_seq;
          retire   <= 1'b1;
          imem_req <= !halt_req;
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles  <= 32'h0;
      perf_retired <= 32'h0;
    end else begin
      if (!halted && perf_cycles != 32'hFFFF_FFFF) perf_cycles <= perf_cycles + 32'h1;
      if (retire && perf_retired != 32'hFFFF_FFFF) perf_retired <= perf_retired + 32'h1;
    end
  end
`else
  assign perf_cycles  = 32'h0;
  assign perf_retired = 32'h0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: stimulus pushes expected retire results,
// a monitor pops and checks them on every retire pulse.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, halt_req, imem_ack, dmem_busy, flags_we, bf;
  logic [31:0] imem_rdata, branchimm;
  logic [3:0]  alu_nzcv;
  logic        imem_req, cond_pass, retire, halted;
  logic [31:0] imem_addr, pc, ir, perf_cycles, perf_retired;
  logic [3:0]  cpsr_nzcv;
  logic [1:0]  state;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  nzcv;
  } exp_t;

  exp_t        scoreboard[$];
  exp_t        monExp;
  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] cycSnap;

  instr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .dmem_busy(dmem_busy), .alu_nzcv(alu_nzcv),
    .flags_we(flags_we), .bf(bf), .branchimm(branchimm), .state(state),
    .pc(pc), .ir(ir), .cpsr_nzcv(cpsr_nzcv), .cond_pass(cond_pass),
    .retire(retire), .halted(halted), .perf_cycles(perf_cycles),
    .perf_retired(perf_retired)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && retire === 1'b1) begin
      if (scoreboard.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected retire: got pc %h, expected no retire", pc);
      end else begin
        monExp = scoreboard.pop_front();
        checkOutput("retire pc", pc, monExp.pc);
        checkOutput("retire nzcv", {28'h0, cpsr_nzcv}, {28'h0, monExp.nzcv});
      end
    end
  end

  // Runs one instruction from fetch to retire; WB inputs are presented only
  // from the last EXEC cycle through WB.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] expPc,
                               input int ackDelay, input bit expPass, input int busy,
                               input bit weIn, input logic [3:0] nzcvIn, input bit bfIn,
                               input logic [23:0] immIn, input bit haltInExec,
                               input logic [31:0] nextPc, input logic [3:0] nextNzcv);
    int waitCnt = 0;
    scoreboard.push_back(exp_t'{pc: nextPc, nzcv: nextNzcv});
    while (imem_req !== 1'b1 && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("imem_req", {31'h0, imem_req}, 32'h1);
    checkOutput("imem_addr", imem_addr, expPc);
    for (int i = 0; i < ackDelay; i++) begin
      @(negedge clk);
      checkOutput("req held", {31'h0, imem_req}, 32'h1);
      checkOutput("addr held", imem_addr, expPc);
      checkOutput("fetch state", {30'h0, state}, 32'h0);
    end
    imem_ack   = 1'b1;
    imem_rdata = instr;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    checkOutput("decode state", {30'h0, state}, 32'h1);
    checkOutput("ir", ir, instr);
    checkOutput("req drop", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    checkOutput("cond_pass", {31'h0, cond_pass}, {31'h0, expPass});
    if (!expPass) begin
      checkOutput("skip state", {30'h0, state}, 32'h0);
    end else begin
      checkOutput("exec state", {30'h0, state}, 32'h2);
      if (haltInExec) halt_req = 1'b1;
      for (int i = 0; i < busy; i++) begin
        dmem_busy = 1'b1;
        @(negedge clk);
        checkOutput("exec stall", {30'h0, state}, 32'h2);
      end
      dmem_busy = 1'b0;
      flags_we  = weIn;
      alu_nzcv  = nzcvIn;
      bf        = bfIn;
      branchimm = {8'h0, immIn};
      @(negedge clk);
      checkOutput("wb state", {30'h0, state}, 32'h3);
      @(negedge clk);
      flags_we  = 1'b0;
      alu_nzcv  = 4'h0;
      bf        = 1'b0;
      branchimm = 32'h0;
      checkOutput("post-wb state", {30'h0, state}, 32'h0);
    end
  endtask

  initial begin
    rst_n = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    dmem_busy = 1'b0; flags_we = 1'b0; alu_nzcv = 4'h0; bf = 1'b0; branchimm = 32'h0;
    repeat (2) @(negedge clk);
    checkOutput("reset state", {30'h0, state}, 32'h0);
    checkOutput("reset pc", pc, 32'h0);
    checkOutput("reset ir", ir, 32'h0);
    checkOutput("reset cpsr", {28'h0, cpsr_nzcv}, 32'h0);
    checkOutput("reset req", {31'h0, imem_req}, 32'h0);
    checkOutput("reset cond_pass", {31'h0, cond_pass}, 32'h0);
    checkOutput("reset retire", {31'h0, retire}, 32'h0);
    checkOutput("reset halted", {31'h0, halted}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("first req", {31'h0, imem_req}, 32'h1);

    //            instr         pc            dly pass busy we nzcv    bf imm         halt nextPc        nzcv
    applyStimulus(32'hE0810002, 32'h0000_0000, 0, 1, 0, 0, 4'b0000, 0, 24'h000000, 0, 32'h0000_0004, 4'b0000);
    applyStimulus(32'hE0912003, 32'h0000_0004, 5, 1, 2, 1, 4'b0100, 0, 24'h000000, 0, 32'h0000_0008, 4'b0100);
    applyStimulus(32'h10810002, 32'h0000_0008, 0, 0, 0, 0, 4'b0000, 0, 24'h000000, 0, 32'h0000_000C, 4'b0100);
    applyStimulus(32'h00910002, 32'h0000_000C, 0, 1, 0, 1, 4'b0000, 0, 24'h000000, 0, 32'h0000_0010, 4'b0000);
    applyStimulus(32'h00810002, 32'h0000_0010, 0, 0, 0, 0, 4'b0000, 0, 24'h000000, 0, 32'h0000_0014, 4'b0000);
    applyStimulus(32'hC0912003, 32'h0000_0014, 1, 1, 0, 1, 4'b1001, 0, 24'h000000, 0, 32'h0000_0018, 4'b1001);
    applyStimulus(32'hCA00000E, 32'h0000_0018, 0, 1, 0, 0, 4'b0000, 1, 24'h000038, 0, 32'h0000_0100, 4'b1001);
    applyStimulus(32'hEAFFFFFE, 32'h0000_0100, 0, 1, 0, 0, 4'b0000, 1, 24'hFFFFFE, 0, 32'h0000_0100, 4'b1001);
    applyStimulus(32'hB0810002, 32'h0000_0100, 0, 0, 0, 0, 4'b0000, 0, 24'h000000, 0, 32'h0000_0104, 4'b1001);
    applyStimulus(32'hF0810002, 32'h0000_0104, 0, 0, 0, 0, 4'b0000, 0, 24'h000000, 0, 32'h0000_0108, 4'b1001);
    applyStimulus(32'hE0810002, 32'h0000_0108, 0, 1, 1, 0, 4'b0000, 0, 24'h000000, 1, 32'h0000_010C, 4'b1001);

    @(negedge clk);
    checkOutput("halted set", {31'h0, halted}, 32'h1);
    checkOutput("halt no req", {31'h0, imem_req}, 32'h0);
    checkOutput("halt state", {30'h0, state}, 32'h0);
`ifdef SEQ_PERF_CNT_EN
    checkOutput("perf_retired", perf_retired, 32'd11);
    cycSnap = perf_cycles;
    repeat (3) @(negedge clk);
    checkOutput("perf_cycles frozen", perf_cycles, cycSnap);
`else
    repeat (3) @(negedge clk);
    checkOutput("perf_cycles off", perf_cycles, 32'h0);
    checkOutput("perf_retired off", perf_retired, 32'h0);
`endif
    checkOutput("halt held", {31'h0, halted}, 32'h1);
    checkOutput("halt req held", {31'h0, imem_req}, 32'h0);
    halt_req = 1'b0;
    @(negedge clk);
    checkOutput("halt clear", {31'h0, halted}, 32'h0);
    checkOutput("resume req", {31'h0, imem_req}, 32'h1);

    applyStimulus(32'hEAFFFFBA, 32'h0000_010C, 0, 1, 0, 1, 4'b0010, 1, 24'hFFFFBA, 0, 32'hFFFF_FFFC, 4'b0010);
    applyStimulus(32'h20810002, 32'hFFFF_FFFC, 0, 1, 0, 0, 4'b0000, 0, 24'h000000, 0, 32'h0000_0000, 4'b0010);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid-fetch reset req", {31'h0, imem_req}, 32'h0);
    checkOutput("mid-fetch reset cpsr", {28'h0, cpsr_nzcv}, 32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    checkOutput("ack ignored ir", ir, 32'h0);
    checkOutput("ack ignored state", {30'h0, state}, 32'h0);
    checkOutput("req after reset", {31'h0, imem_req}, 32'h1);

    repeat (2) @(negedge clk);
    checkOutput("scoreboard drained", scoreboard.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
